// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package mcycle_pkg;

  localparam int OPCODE_W = 6;
  localparam logic [OPCODE_W-1:0] OP_RTYPE_DEF = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_HALT_DEF  = 6'b111111;
  localparam int FETCH_TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Retire counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Counts FETCH cycles without an ack; o_expired marks the last permitted miss.
module fetch_timer #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(FETCH_TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // Miss counter: cleared outside FETCH, never runs past the expiry point.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en && !o_expired) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Expired while r_cnt equals the misses already seen: a miss now is the FETCH_TIMEOUT-th.
  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/mcycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer with halt, illegal-opcode and fetch-timeout handling.
module mcycle_seq
  import mcycle_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] OP_RTYPE = OP_RTYPE_DEF,
  parameter logic [OPCODE_W-1:0] OP_HALT  = OP_HALT_DEF,
  parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                ir_load,
  output logic                rf_re,
  output logic                alu_en,
  output logic                rf_we,
  output logic                pc_en,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic                timeout,
  output logic [15:0]         retire_cnt
);

  state_t      r_state;
  state_t      w_next;
  logic        w_expired;
  logic        w_cnt_en;
  logic        w_clear;
  logic [15:0] r_retire_cnt;
  logic        r_halted;
  logic        r_illegal;
  logic        r_timeout;

  assign w_cnt_en = (r_state == S_FETCH) && !imem_ack;
  assign w_clear  = rst || (r_state != S_FETCH);

  fetch_timer #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk       (clk),
    .i_clear   (w_clear),
    .i_count_en(w_cnt_en),
    .o_expired (w_expired)
  );

  // Next-state decode and per-state datapath strobes.
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    rf_re    = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    pc_en    = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
        else       w_next = S_IDLE;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        busy     = 1'b1;
        // An ack on the final allowed cycle still beats the timeout.
        if (imem_ack)       w_next = S_DECODE;
        else if (w_expired) w_next = S_ERR;
        else                w_next = S_FETCH;
      end
      S_DECODE: begin
        rf_re = 1'b1;
        busy  = 1'b1;
        if (opcode == OP_RTYPE)     w_next = S_EXEC;
        else if (opcode == OP_HALT) w_next = S_HALT;
        else                        w_next = S_ERR;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        busy   = 1'b1;
        w_next = S_WB;
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_en = 1'b1;
        busy  = 1'b1;
        if (stop) w_next = S_IDLE;
        else      w_next = S_FETCH;
      end
      S_HALT: begin
        if (start) w_next = S_FETCH;
        else       w_next = S_HALT;
      end
      S_ERR: begin
        w_next = S_ERR;
      end
      default: begin
        w_next = S_ERR;
      end
    endcase
  end

  // State, retire counter and sticky status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_retire_cnt <= 16'd0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == S_HALT);
      if (r_state == S_WB) r_retire_cnt <= sat_inc16(r_retire_cnt);
      if (r_state == S_FETCH && w_next == S_ERR) r_timeout <= 1'b1;
      if (r_state == S_DECODE && w_next == S_ERR) r_illegal <= 1'b1;
    end
  end

  assign halted     = r_halted;
  assign illegal    = r_illegal;
  assign timeout    = r_timeout;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mcycle_seq.sv
// Transaction-level reference model of the sequencer driven by randomized instruction streams.
module tb_mcycle_seq;

  localparam int FT = 16;
  localparam logic [5:0] OP_R = 6'b000000;
  localparam logic [5:0] OP_H = 6'b111111;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_ERR  = 3;

  logic clk, rst, start, stop, imem_ack;
  logic [5:0] opcode;
  logic imem_req, ir_load, rf_re, alu_en, rf_we, pc_en;
  logic busy, halted, illegal, timeout;
  logic [15:0] retire_cnt;

  mcycle_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .imem_req(imem_req), .imem_ack(imem_ack), .opcode(opcode),
    .ir_load(ir_load), .rf_re(rf_re), .alu_en(alu_en), .rf_we(rf_we), .pc_en(pc_en),
    .busy(busy), .halted(halted), .illegal(illegal), .timeout(timeout),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  v;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Model state: what the sequencer must be doing, at the instruction level.
  int mode = M_IDLE;
  logic [15:0] m_cnt = 16'd0;
  logic m_halted = 1'b0, m_illegal = 1'b0, m_timeout = 1'b0;

  wire [9:0] act = {imem_req, ir_load, rf_re, alu_en, rf_we, pc_en, busy, halted, illegal, timeout};

  // Compare process: one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e.v || retire_cnt !== e.c) begin
        n_err++;
        $display("FAIL cycle_%0d: got req,irl,rre,alu,we,pc,busy,hlt,ill,to=%b cnt=%h, expected %b cnt=%h",
                 cyc, act, retire_cnt, e.v, e.c);
      end
    end
  end

  function automatic logic rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(63));
  endfunction

  function automatic logic [9:0] vec(input logic req, irl, rre, alu, we, pc, bsy);
    return {req, irl, rre, alu, we, pc, bsy, m_halted, m_illegal, m_timeout};
  endfunction

  task automatic lit(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, a, e);
    end
  endtask

  task automatic step(input logic r, s, p, a, input logic [5:0] op, input logic [9:0] v);
    rst = r; start = s; stop = p; imem_ack = a; opcode = op;
    exp_q.push_back({v, m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, rnd(50), rnd(50), rnd(50), rop(), vec(0, 0, 0, 0, 0, 0, 0));
    m_cnt = 16'd0; m_halted = 1'b0; m_illegal = 1'b0; m_timeout = 1'b0;
    step(1'b1, 1'b1, rnd(50), rnd(50), rop(), vec(0, 0, 0, 0, 0, 0, 0));
    mode = M_IDLE;
  endtask

  task automatic idle_phase(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd(50), rnd(50), rop(), vec(0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, rnd(50), rnd(50), rop(), vec(0, 0, 0, 0, 0, 0, 0));
    mode = M_RUN;
  endtask

  task automatic halt_phase(input int n, input logic exit_stop);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd(50), rnd(50), rop(), vec(0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, exit_stop, rnd(50), rop(), vec(0, 0, 0, 0, 0, 0, 0));
    m_halted = 1'b0;
    mode = M_RUN;
  endtask

  task automatic err_phase(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd(50), rnd(50), rnd(50), rop(), vec(0, 0, 0, 0, 0, 0, 0));
  endtask

  // One instruction: `delay` ack-less fetch cycles, then ack, decode and (for R-type) exec/wb.
  task automatic run_instr(input int delay, input logic [5:0] op, input logic stp);
    for (int i = 0; i < delay && i < FT; i++)
      step(1'b0, rnd(30), rnd(30), 1'b0, rop(), vec(1, 0, 0, 0, 0, 0, 1));
    if (delay >= FT) begin
      m_timeout = 1'b1;
      mode = M_ERR;
      return;
    end
    step(1'b0, rnd(30), rnd(30), 1'b1, op, vec(1, 1, 0, 0, 0, 0, 1));
    step(1'b0, rnd(30), rnd(30), rnd(50), op, vec(0, 0, 1, 0, 0, 0, 1));
    if (op == OP_R) begin
      step(1'b0, rnd(30), rnd(30), rnd(50), rop(), vec(0, 0, 0, 1, 0, 0, 1));
      step(1'b0, rnd(30), stp, rnd(50), rop(), vec(0, 0, 0, 0, 1, 1, 1));
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      mode = stp ? M_IDLE : M_RUN;
    end else if (op == OP_H) begin
      m_halted = 1'b1;
      mode = M_HALT;
    end else begin
      m_illegal = 1'b1;
      mode = M_ERR;
    end
  endtask

  initial begin
    int r, d;
    logic [5:0] op;
    rst = 1'b1; start = 1'b0; stop = 1'b0; imem_ack = 1'b0; opcode = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    lit("reset_cnt", 32'(retire_cnt), 32'd0);
    lit("reset_busy", 32'(busy), 32'd0);

    // Back-to-back R-type with ack tied high, stop on the third writeback.
    idle_phase(0);
    run_instr(0, OP_R, 1'b0);
    run_instr(0, OP_R, 1'b0);
    run_instr(0, OP_R, 1'b1);
    lit("three_retired", 32'(retire_cnt), 32'd3);
    lit("idle_after_stop", 32'(busy), 32'd0);

    // Ack delayed by five cycles.
    idle_phase(1);
    run_instr(5, OP_R, 1'b1);
    lit("delayed_ack_cnt", 32'(retire_cnt), 32'd4);

    // Ack on the last allowed fetch cycle, then no ack at all.
    idle_phase(0);
    run_instr(FT - 1, OP_R, 1'b1);
    lit("ack_on_16_no_timeout", 32'(timeout), 32'd0);
    lit("ack_on_16_cnt", 32'(retire_cnt), 32'd5);
    idle_phase(0);
    run_instr(FT, OP_R, 1'b0);
    lit("timeout_set", 32'(timeout), 32'd1);
    lit("timeout_busy", 32'(busy), 32'd0);
    err_phase(3);
    lit("timeout_sticky", 32'(timeout), 32'd1);
    do_reset();

    // Illegal opcode.
    idle_phase(0);
    run_instr(0, 6'b000101, 1'b0);
    lit("illegal_set", 32'(illegal), 32'd1);
    err_phase(4);
    lit("illegal_sticky", 32'(illegal), 32'd1);
    do_reset();
    lit("illegal_cleared", 32'(illegal), 32'd0);

    // HALT word, resume with start and stop together, stop in writeback.
    idle_phase(0);
    run_instr(0, OP_R, 1'b0);
    run_instr(0, OP_H, 1'b0);
    lit("halted_set", 32'(halted), 32'd1);
    lit("halt_not_counted", 32'(retire_cnt), 32'd1);
    halt_phase(2, 1'b1);
    run_instr(0, OP_R, 1'b1);
    lit("halted_cleared", 32'(halted), 32'd0);
    lit("resume_cnt", 32'(retire_cnt), 32'd2);

    // Saturation near the top of the counter.
    force dut.r_retire_cnt = 16'hFFFD;
    #1;
    release dut.r_retire_cnt;
    m_cnt = 16'hFFFD;
    idle_phase(0);
    run_instr(0, OP_R, 1'b0);
    run_instr(0, OP_R, 1'b0);
    run_instr(0, OP_R, 1'b1);
    lit("saturated", 32'(retire_cnt), 32'h0000FFFF);

    // Reset in the middle of EXEC.
    idle_phase(0);
    step(1'b0, 1'b0, 1'b0, 1'b1, OP_R, vec(1, 1, 0, 0, 0, 0, 1));
    step(1'b0, 1'b0, 1'b0, 1'b0, OP_R, vec(0, 0, 1, 0, 0, 0, 1));
    step(1'b1, 1'b1, 1'b0, 1'b0, OP_R, vec(0, 0, 0, 1, 0, 0, 1));
    m_cnt = 16'd0; mode = M_IDLE;
    step(1'b0, 1'b0, 1'b0, 1'b0, OP_R, vec(0, 0, 0, 0, 0, 0, 0));
    lit("rst_mid_exec_cnt", 32'(retire_cnt), 32'd0);

    // Randomized instruction streams.
    for (int it = 0; it < 300; it++) begin
      case (mode)
        M_IDLE: idle_phase($urandom_range(2));
        M_RUN: begin
          r = $urandom_range(99);
          if (r < 80)      d = $urandom_range(4);
          else if (r < 92) d = $urandom_range(15, 5);
          else             d = $urandom_range(18, 16);
          r = $urandom_range(99);
          if (r < 70)      op = OP_R;
          else if (r < 85) op = OP_H;
          else             op = 6'($urandom_range(62, 1));
          run_instr(d, op, rnd(30));
        end
        M_HALT: halt_phase($urandom_range(2), rnd(50));
        M_ERR: begin
          err_phase($urandom_range(3, 1));
          do_reset();
        end
        default: do_reset();
      endcase
    end

    @(posedge clk);
    #1;
    lit("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
